fft_ctrl: RTL and testbench

In-place radix-2 DIT FFT sequencer that drives the single shared `butterfly` datapath against a dual-port sample RAM and a twiddle ROM. On `start`, it walks all LOG2N stages. For each butterfly it issues read addresses, the twiddle address and `butterfly` enable, then the delayed write-back addresses. It inserts a pipeline drain between stages so each stage reads only fully written results. Input samples are already stored in bit-reversed order by the loader upstream.

---
 rtl/fft_pkg.sv | 33 +++
 rtl/fft_addr_gen.sv | 34 +++
 rtl/fft_ctrl.sv | 152 +++++++++++++++
 tb/tb_fft_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared types and width helpers for the radix-2 DIT FFT sequencer.
package fft_pkg;

    // Controller states
    typedef enum logic [2:0] {
        IDLE,
        RUN,
        DRAIN,
        FLUSH,
        DONE
    } state_t;

    // Read-to-write latency through RAM/ROM and the butterfly
    function automatic int pipe_len(input int rd_lat, input int bf_lat);
        return rd_lat + bf_lat;
    endfunction

    // Width of the stage index (at least one bit)
    function automatic int stage_w(input int log2n);
        return (log2n > 1) ? $clog2(log2n) : 1;
    endfunction

    // Width of the twiddle ROM index (N/2 entries)
    function automatic int tw_w(input int log2n);
        return log2n - 1;
    endfunction

    // Width of the drain/flush counter, which must reach PIPE
    function automatic int cnt_w(input int pipe);
        return $clog2(pipe + 1);
    endfunction

endpackage

// File: rtl/fft_addr_gen.sv
// Combinational butterfly address generator: (stage s, butterfly j) -> (a, b, k).
module fft_addr_gen
    import fft_pkg::*;
#(
    parameter int LOG2N = 3
) (
    input  logic [stage_w(LOG2N)-1:0] s,
    input  logic [tw_w(LOG2N)-1:0]    j,
    output logic [LOG2N-1:0]          a,
    output logic [LOG2N-1:0]          b,
    output logic [tw_w(LOG2N)-1:0]    k
);

    localparam int SW = stage_w(LOG2N);
    localparam logic [SW-1:0]    S_TOP = SW'(LOG2N - 1);
    localparam logic [LOG2N-1:0] ONE   = LOG2N'(1);

    logic [LOG2N-1:0] jw;
    logic [LOG2N-1:0] half;
    logic [LOG2N-1:0] pos;
    logic [LOG2N-1:0] grp;

    // Split j into group and position; a inserts a zero bit at position s
    always_comb begin
        jw   = {1'b0, j};
        half = ONE << s;
        pos  = jw & (half - ONE);
        grp  = jw >> s;
        a    = ((grp << s) << 1) | pos;
        b    = a + half;
        k    = pos[LOG2N-2:0] << (S_TOP - s);
    end

endmodule

// File: rtl/fft_ctrl.sv
// In-place radix-2 DIT FFT sequencer: walks all stages, issues reads,
// twiddle indices and butterfly enables, and delays addresses to write-back.
module fft_ctrl
    import fft_pkg::*;
#(
    parameter int LOG2N  = 3,
    parameter int RD_LAT = 1,
    parameter int BF_LAT = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    output logic [stage_w(LOG2N)-1:0] stage,
    output logic                      rd_en,
    output logic [LOG2N-1:0]          rd_addr_a,
    output logic [LOG2N-1:0]          rd_addr_b,
    output logic [tw_w(LOG2N)-1:0]    tw_addr,
    output logic                      bf_enable,
    output logic                      wr_en,
    output logic [LOG2N-1:0]          wr_addr_a,
    output logic [LOG2N-1:0]          wr_addr_b
);

    localparam int PIPE = pipe_len(RD_LAT, BF_LAT);
    localparam int SW   = stage_w(LOG2N);
    localparam int JW   = tw_w(LOG2N);
    localparam int CW   = cnt_w(PIPE);

    localparam logic [SW-1:0] S_LAST    = SW'(LOG2N - 1);
    localparam logic [SW-1:0] S_ONE     = SW'(1);
    localparam logic [JW-1:0] J_LAST    = '1;
    localparam logic [JW-1:0] J_ONE     = JW'(1);
    localparam logic [CW-1:0] DRAIN_END = CW'(PIPE - 1);
    localparam logic [CW-1:0] FLUSH_END = CW'(PIPE);
    localparam logic [CW-1:0] C_ONE     = CW'(1);

    state_t           state;
    logic [SW-1:0]    s;
    logic [JW-1:0]    j;
    logic [CW-1:0]    cnt;

    logic [LOG2N-1:0] a;
    logic [LOG2N-1:0] b;
    logic [JW-1:0]    k;

    logic [PIPE-1:0]  vld_p;
    logic [LOG2N-1:0] addr_a_p [PIPE];
    logic [LOG2N-1:0] addr_b_p [PIPE];

    fft_addr_gen #(
        .LOG2N (LOG2N)
    ) u_addr_gen (
        .s (s),
        .j (j),
        .a (a),
        .b (b),
        .k (k)
    );

    // Sequencer FSM: stage/butterfly counters and registered read-side outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            s         <= '0;
            j         <= '0;
            cnt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            stage     <= '0;
            rd_en     <= 1'b0;
            rd_addr_a <= '0;
            rd_addr_b <= '0;
            tw_addr   <= '0;
        end else begin
            rd_en <= 1'b0;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= RUN;
                        s     <= '0;
                        j     <= '0;
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    rd_en     <= 1'b1;
                    rd_addr_a <= a;
                    rd_addr_b <= b;
                    tw_addr   <= k;
                    stage     <= s;
                    j         <= j + J_ONE;
                    cnt       <= '0;
                    if (j == J_LAST) begin
                        state <= (s == S_LAST) ? FLUSH : DRAIN;
                    end
                end
                DRAIN: begin
                    // Hold off reads until the last write of this stage lands
                    cnt <= cnt + C_ONE;
                    if (cnt == DRAIN_END) begin
                        state <= RUN;
                        s     <= s + S_ONE;
                    end
                end
                FLUSH: begin
                    // One extra count so done follows the final write
                    cnt <= cnt + C_ONE;
                    if (cnt == FLUSH_END) begin
                        state <= DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    stage <= '0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Delay line: shifts read strobe and addresses toward write-back
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p <= '0;
            for (int i = 0; i < PIPE; i++) begin
                addr_a_p[i] <= '0;
                addr_b_p[i] <= '0;
            end
        end else begin
            vld_p       <= {vld_p[PIPE-2:0], rd_en};
            addr_a_p[0] <= rd_addr_a;
            addr_b_p[0] <= rd_addr_b;
            for (int i = 1; i < PIPE; i++) begin
                addr_a_p[i] <= addr_a_p[i-1];
                addr_b_p[i] <= addr_b_p[i-1];
            end
        end
    end

    assign bf_enable = vld_p[RD_LAT-1];
    assign wr_en     = vld_p[PIPE-1];
    assign wr_addr_a = addr_a_p[PIPE-1];
    assign wr_addr_b = addr_b_p[PIPE-1];

endmodule

// File: tb/tb_fft_ctrl.sv
// Testbench for fft_ctrl: N=8 default instance and N=16 / PIPE=5 instance,
// compared cycle by cycle against an arithmetic schedule model.
module tb_fft_ctrl;

    localparam int L1 = 3;
    localparam int R1 = 1;
    localparam int B1 = 1;
    localparam int L2 = 4;
    localparam int R2 = 2;
    localparam int B2 = 3;

    logic clk    = 1'b0;
    logic rst    = 1'b1;
    logic start1 = 1'b0;
    logic start2 = 1'b0;

    logic          busy1, done1, rd_en1, bfe1, we1;
    logic [1:0]    stage1;
    logic [L1-1:0] ra1, rb1, wa1, wb1;
    logic [L1-2:0] tw1;

    logic          busy2, done2, rd_en2, bfe2, we2;
    logic [1:0]    stage2;
    logic [L2-1:0] ra2, rb2, wa2, wb2;
    logic [L2-2:0] tw2;

    int checks = 0;
    int errors = 0;

    logic [31:0] obs  [11];
    logic [31:0] expv [11];
    string fname [11] = '{"rd_en", "rd_addr_a", "rd_addr_b", "tw_addr", "stage",
                          "bf_enable", "wr_en", "wr_addr_a", "wr_addr_b", "done", "busy"};

    always #5 clk = ~clk;

    fft_ctrl #(.LOG2N(L1), .RD_LAT(R1), .BF_LAT(B1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1),
        .stage(stage1), .rd_en(rd_en1), .rd_addr_a(ra1), .rd_addr_b(rb1),
        .tw_addr(tw1), .bf_enable(bfe1), .wr_en(we1), .wr_addr_a(wa1), .wr_addr_b(wb1)
    );

    fft_ctrl #(.LOG2N(L2), .RD_LAT(R2), .BF_LAT(B2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .busy(busy2), .done(done2),
        .stage(stage2), .rd_en(rd_en2), .rd_addr_a(ra2), .rd_addr_b(rb2),
        .tw_addr(tw2), .bf_enable(bfe2), .wr_en(we2), .wr_addr_a(wa2), .wr_addr_b(wb2)
    );

    // Schedule model: read x cycles after the start edge, from plain arithmetic
    function automatic void rd_info(input int log2n, input int pipe, input int x,
                                    output int v, output int a, output int b,
                                    output int k, output int s);
        int hn;
        int per;
        int off;
        int half;
        hn  = (1 << log2n) / 2;
        per = hn + pipe;
        v = 0; a = 0; b = 0; k = 0; s = 0;
        if (x >= 1 && x <= log2n * per) begin
            s   = (x - 1) / per;
            off = (x - 1) % per;
            if (off < hn) begin
                v    = 1;
                half = 1 << s;
                a    = (off / half) * 2 * half + (off % half);
                b    = a + half;
                k    = (off % half) * (hn / half);
            end
        end
    endfunction

    task automatic build_exp(input int which, input int c);
        int log2n, rdl, pipe, last, v, a, b, k, s;
        log2n = (which == 0) ? L1 : L2;
        rdl   = (which == 0) ? R1 : R2;
        pipe  = (which == 0) ? (R1 + B1) : (R2 + B2);
        last  = log2n * ((1 << log2n) / 2 + pipe);
        rd_info(log2n, pipe, c, v, a, b, k, s);
        expv[0] = 32'(v); expv[1] = 32'(a); expv[2] = 32'(b); expv[3] = 32'(k); expv[4] = 32'(s);
        rd_info(log2n, pipe, c - rdl, v, a, b, k, s);
        expv[5] = 32'(v);
        rd_info(log2n, pipe, c - pipe, v, a, b, k, s);
        expv[6] = 32'(v); expv[7] = 32'(a); expv[8] = 32'(b);
        expv[9]  = 32'(c == last + 1);
        expv[10] = 32'(c >= 0 && c <= last);
    endtask

    task automatic sample_obs(input int which);
        if (which == 0) begin
            obs[0] = 32'(rd_en1); obs[1] = 32'(ra1); obs[2] = 32'(rb1); obs[3] = 32'(tw1);
            obs[4] = 32'(stage1); obs[5] = 32'(bfe1); obs[6] = 32'(we1); obs[7] = 32'(wa1);
            obs[8] = 32'(wb1); obs[9] = 32'(done1); obs[10] = 32'(busy1);
        end else begin
            obs[0] = 32'(rd_en2); obs[1] = 32'(ra2); obs[2] = 32'(rb2); obs[3] = 32'(tw2);
            obs[4] = 32'(stage2); obs[5] = 32'(bfe2); obs[6] = 32'(we2); obs[7] = 32'(wa2);
            obs[8] = 32'(wb2); obs[9] = 32'(done2); obs[10] = 32'(busy2);
        end
    endtask

    task automatic drive_start(input int which, input logic v);
        if (which == 0) start1 = v;
        else            start2 = v;
    endtask

    // One full transform from a start pulse; optional random start noise while busy
    task automatic run_trace(input int which, input bit inject, input string tag);
        int log2n, pipe, hn, last, nwr, ndone;
        log2n = (which == 0) ? L1 : L2;
        pipe  = (which == 0) ? (R1 + B1) : (R2 + B2);
        hn    = (1 << log2n) / 2;
        last  = log2n * (hn + pipe);
        nwr   = 0;
        ndone = 0;
        @(negedge clk);
        drive_start(which, 1'b1);
        for (int c = 0; c <= last + 2; c++) begin
            @(negedge clk);
            drive_start(which, (inject && c <= last + 1) ? 1'($urandom_range(0, 1)) : 1'b0);
            sample_obs(which);
            build_exp(which, c);
            for (int f = 0; f < 11; f++) begin
                if (f >= 1 && f <= 4 && expv[0] == 0) continue;
                if (f >= 7 && f <= 8 && expv[6] == 0) continue;
                checks++;
                if (obs[f] !== expv[f]) begin
                    errors++;
                    $display("FAIL %s %s cyc=%0d got=%0d exp=%0d", tag, fname[f], c, obs[f], expv[f]);
                end
            end
            if (obs[0] === 32'd1 && obs[4] !== 32'd0) begin
                checks++;
                if (nwr < int'(obs[4]) * hn) begin
                    errors++;
                    $display("FAIL %s read_before_write cyc=%0d writes=%0d need=%0d",
                             tag, c, nwr, int'(obs[4]) * hn);
                end
            end
            if (obs[6] === 32'd1) nwr++;
            if (obs[9] === 32'd1) ndone++;
        end
        checks++;
        if (ndone != 1) begin
            errors++;
            $display("FAIL %s done_count got=%0d exp=1", tag, ndone);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int w = 0; w < 2; w++) begin
            sample_obs(w);
            for (int f = 0; f < 11; f++) begin
                checks++;
                if (obs[f] !== 32'd0) begin
                    errors++;
                    $display("FAIL reset dut%0d %s got=%0d exp=0", w + 1, fname[f], obs[f]);
                end
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_full_run();
        run_trace(0, 1'b0, "run8");
    endtask

    task automatic test_start_held();
        int last, ndone, done_cyc, stray, first_rd;
        last = L1 * ((1 << L1) / 2 + R1 + B1);
        ndone = 0; done_cyc = -1; stray = 0; first_rd = -1;
        @(negedge clk);
        start1 = 1'b1;
        for (int c = 0; c <= last + 6; c++) begin
            @(negedge clk);
            if (done1) begin
                ndone++;
                done_cyc = c;
            end
            if (c > last - (R1 + B1) && c < last + 4 && rd_en1) stray++;
            if (c > last && first_rd < 0 && rd_en1) first_rd = c;
        end
        start1 = 1'b0;
        checks++;
        if (ndone != 1) begin errors++; $display("FAIL held done_count got=%0d exp=1", ndone); end
        checks++;
        if (done_cyc != last + 1) begin errors++; $display("FAIL held done_cycle got=%0d exp=%0d", done_cyc, last + 1); end
        checks++;
        if (stray != 0) begin errors++; $display("FAIL held early_restart got=%0d exp=0", stray); end
        checks++;
        if (first_rd != last + 4) begin errors++; $display("FAIL held restart_read got=%0d exp=%0d", first_rd, last + 4); end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset_mid();
        int act;
        act = 0;
        @(negedge clk);
        start1 = 1'b1;
        for (int c = 0; c <= 9; c++) begin
            @(negedge clk);
            start1 = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        sample_obs(0);
        for (int f = 0; f < 11; f++) begin
            checks++;
            if (obs[f] !== 32'd0) begin
                errors++;
                $display("FAIL midreset %s got=%0d exp=0", fname[f], obs[f]);
            end
        end
        rst = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (we1 !== 1'b0 || rd_en1 !== 1'b0 || busy1 !== 1'b0) act++;
        end
        checks++;
        if (act != 0) begin errors++; $display("FAIL midreset activity got=%0d exp=0", act); end
        run_trace(0, 1'b0, "restart8");
    endtask

    task automatic test_random();
        for (int it = 0; it < 4; it++) begin
            repeat ($urandom_range(0, 5)) @(negedge clk);
            run_trace(0, 1'b1, "rand8");
        end
        run_trace(1, 1'b1, "rand16");
    endtask

    task automatic test_pipe5();
        run_trace(1, 1'b0, "run16");
    endtask

    initial begin
        test_reset();
        test_full_run();
        test_start_held();
        test_reset_mid();
        test_random();
        test_pipe5();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
